// File: rtl/match_sequencer.sv
// Trade-matching sequencer between order-book top-of-book and the spread unit.
// Captures best bid/ask in IDLE. It tests the captured pair for a cross.
// On a cross it issues a one-cycle match strobe with fill pulses.
// It then lets the book settle before it samples the book again.
module match_sequencer #(
  parameter int unsigned PRICE_W    = 8,
  parameter int unsigned QTY_W      = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               bid_valid,
  input  logic [PRICE_W-1:0] bid_price,
  input  logic [QTY_W-1:0]   bid_qty,
  input  logic               ask_valid,
  input  logic [PRICE_W-1:0] ask_price,
  input  logic [QTY_W-1:0]   ask_qty,
  input  logic               book_update,
  output logic               match_signal,
  output logic               enable_count,
  output logic [PRICE_W-1:0] buy_price,
  output logic [PRICE_W-1:0] sell_price,
  output logic [QTY_W-1:0]   trade_qty,
  output logic               bid_fill,
  output logic               ask_fill,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StMatch,
    StSettle,
    StHold
  } state_e;

  state_e     state_q;
  logic [7:0] gap_q;
  logic       upd_seen_q;

  // Busy is decoded from the state register only.
  assign busy = (state_q != StIdle);

  // Sequencer FSM with registered outputs; the capture registers double as price/qty outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      gap_q        <= 8'd0;
      upd_seen_q   <= 1'b0;
      match_signal <= 1'b0;
      enable_count <= 1'b0;
      buy_price    <= '0;
      sell_price   <= '0;
      trade_qty    <= '0;
      bid_fill     <= 1'b0;
      ask_fill     <= 1'b0;
      match_count  <= '0;
    end else begin
      enable_count <= run;
      match_signal <= 1'b0;
      bid_fill     <= 1'b0;
      ask_fill     <= 1'b0;
      // Remember updates seen while busy; a later transition to IDLE clears it.
      if (state_q != StIdle && book_update) begin
        upd_seen_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          upd_seen_q <= 1'b0;
          if (run && bid_valid && ask_valid) begin
            buy_price  <= bid_price;
            sell_price <= ask_price;
            // min() is zero iff either side has zero quantity.
            trade_qty  <= (bid_qty < ask_qty) ? bid_qty : ask_qty;
            state_q    <= StCheck;
          end
        end
        StCheck: begin
          if (!run) begin
            state_q    <= StIdle;
            upd_seen_q <= 1'b0;
          end else if (buy_price >= sell_price && trade_qty != '0) begin
            state_q      <= StMatch;
            match_signal <= 1'b1;
            bid_fill     <= 1'b1;
            ask_fill     <= 1'b1;
            match_count  <= match_count + 1'b1;
          end else begin
            state_q <= StHold;
          end
        end
        StMatch: begin
          // The strobe is already committed; run is not consulted here.
          gap_q   <= 8'(GAP_CYCLES);
          state_q <= StSettle;
        end
        StSettle: begin
          if (!run || gap_q <= 8'd1) begin
            gap_q      <= 8'd0;
            state_q    <= StIdle;
            upd_seen_q <= 1'b0;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        StHold: begin
          if (!run || book_update || upd_seen_q) begin
            state_q    <= StIdle;
            upd_seen_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          upd_seen_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: dut0 uses default parameters,
// dut1 (GAP_CYCLES=3, CNT_W=4) is used for strobe spacing and counter wrap.
module tb_match_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       bid_valid;
  logic [7:0] bid_price;
  logic [7:0] bid_qty;
  logic       ask_valid;
  logic [7:0] ask_price;
  logic [7:0] ask_qty;
  logic       book_update;

  logic        m0_match, m0_en, m0_bfill, m0_afill, m0_busy;
  logic [7:0]  m0_buy, m0_sell, m0_qty;
  logic [15:0] m0_count;

  logic        m1_match, m1_en, m1_bfill, m1_afill, m1_busy;
  logic [7:0]  m1_buy, m1_sell, m1_qty;
  logic [3:0]  m1_count;

  int checks   = 0;
  int failures = 0;

  match_sequencer dut0 (
    .clk(clk), .reset(reset), .run(run),
    .bid_valid(bid_valid), .bid_price(bid_price), .bid_qty(bid_qty),
    .ask_valid(ask_valid), .ask_price(ask_price), .ask_qty(ask_qty),
    .book_update(book_update),
    .match_signal(m0_match), .enable_count(m0_en),
    .buy_price(m0_buy), .sell_price(m0_sell), .trade_qty(m0_qty),
    .bid_fill(m0_bfill), .ask_fill(m0_afill),
    .match_count(m0_count), .busy(m0_busy)
  );

  match_sequencer #(
    .CNT_W(4),
    .GAP_CYCLES(3)
  ) dut1 (
    .clk(clk), .reset(reset), .run(run),
    .bid_valid(bid_valid), .bid_price(bid_price), .bid_qty(bid_qty),
    .ask_valid(ask_valid), .ask_price(ask_price), .ask_qty(ask_qty),
    .book_update(book_update),
    .match_signal(m1_match), .enable_count(m1_en),
    .buy_price(m1_buy), .sell_price(m1_sell), .trade_qty(m1_qty),
    .bid_fill(m1_bfill), .ask_fill(m1_afill),
    .match_count(m1_count), .busy(m1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_book(input logic [7:0] bp, input logic [7:0] bq,
                          input logic [7:0] ap, input logic [7:0] aq);
    bid_valid = 1'b1;
    ask_valid = 1'b1;
    bid_price = bp;
    bid_qty   = bq;
    ask_price = ap;
    ask_qty   = aq;
  endtask

  initial begin
    int seen;
    int cyc;
    int last;
    reset = 1'b0; run = 1'b0; book_update = 1'b0;
    bid_valid = 1'b0; bid_price = '0; bid_qty = '0;
    ask_valid = 1'b0; ask_price = '0; ask_qty = '0;
    step(2);
    check_eq("rst_match", m0_match, 0);
    check_eq("rst_busy", m0_busy, 0);
    check_eq("rst_count", m0_count, 0);
    check_eq("rst_buy", m0_buy, 0);
    check_eq("rst_en", m0_en, 0);
    check_eq("rst_busy1", m1_busy, 0);
    reset = 1'b1;

    // Cross: bid 60/q5 vs ask 55/q3; valids stay high to force a re-capture.
    run = 1'b1;
    set_book(8'd60, 8'd5, 8'd55, 8'd3);
    step(1);
    check_eq("x_chk_busy", m0_busy, 1);
    check_eq("x_chk_match", m0_match, 0);
    check_eq("x_en", m0_en, 1);
    step(1);
    check_eq("x_match", m0_match, 1);
    check_eq("x_bfill", m0_bfill, 1);
    check_eq("x_afill", m0_afill, 1);
    check_eq("x_buy", m0_buy, 60);
    check_eq("x_sell", m0_sell, 55);
    check_eq("x_qty", m0_qty, 3);
    check_eq("x_count", m0_count, 1);
    check_eq("x_busy", m0_busy, 1);
    step(1);
    check_eq("x_match_off", m0_match, 0);
    check_eq("x_bfill_off", m0_bfill, 0);
    check_eq("x_settle_busy", m0_busy, 1);
    step(2);
    check_eq("x_idle", m0_busy, 0);
    step(2);
    check_eq("x_rematch", m0_match, 1);
    check_eq("x_count2", m0_count, 2);
    bid_valid = 1'b0; ask_valid = 1'b0;
    step(3);
    check_eq("x_idle2", m0_busy, 0);

    // No cross: bid 50 < ask 52 parks in HOLD until a book update.
    set_book(8'd50, 8'd5, 8'd52, 8'd3);
    step(2);
    check_eq("nc_match", m0_match, 0);
    check_eq("nc_busy", m0_busy, 1);
    step(3);
    check_eq("nc_hold", m0_busy, 1);
    check_eq("nc_count", m0_count, 2);
    book_update = 1'b1; bid_price = 8'd53; bid_qty = 8'd2;
    step(1);
    check_eq("nc_exit", m0_busy, 0);
    book_update = 1'b0;
    step(2);
    check_eq("nc_match2", m0_match, 1);
    check_eq("nc_qty", m0_qty, 2);
    check_eq("nc_buy", m0_buy, 53);
    check_eq("nc_sell", m0_sell, 52);
    check_eq("nc_count3", m0_count, 3);
    bid_valid = 1'b0; ask_valid = 1'b0;
    step(3);

    // Equal prices count as a cross.
    set_book(8'd40, 8'd4, 8'd40, 8'd4);
    step(2);
    check_eq("eq_match", m0_match, 1);
    check_eq("eq_qty", m0_qty, 4);
    check_eq("eq_count", m0_count, 4);
    bid_valid = 1'b0; ask_valid = 1'b0;
    step(3);

    // Zero bid quantity: HOLD, no fills.
    set_book(8'd40, 8'd0, 8'd40, 8'd4);
    step(2);
    check_eq("zq_match", m0_match, 0);
    check_eq("zq_bfill", m0_bfill, 0);
    check_eq("zq_afill", m0_afill, 0);
    check_eq("zq_busy", m0_busy, 1);
    check_eq("zq_qty", m0_qty, 0);
    run = 1'b0; bid_valid = 1'b0; ask_valid = 1'b0;
    step(1);
    check_eq("zq_run_exit", m0_busy, 0);
    check_eq("zq_en", m0_en, 0);
    run = 1'b1;

    // Update during CHECK must release the following HOLD.
    set_book(8'd50, 8'd5, 8'd52, 8'd3);
    step(1);
    book_update = 1'b1;
    step(1);
    book_update = 1'b0;
    check_eq("us_hold", m0_busy, 1);
    bid_valid = 1'b0; ask_valid = 1'b0;
    step(1);
    check_eq("us_exit", m0_busy, 0);

    // The remembered update is cleared at IDLE: a fresh HOLD must persist.
    set_book(8'd50, 8'd5, 8'd52, 8'd3);
    step(5);
    check_eq("us_clear", m0_busy, 1);
    run = 1'b0; bid_valid = 1'b0; ask_valid = 1'b0;
    step(1);
    run = 1'b1;

    // run dropped in CHECK: back to IDLE without a strobe.
    set_book(8'd60, 8'd5, 8'd55, 8'd3);
    step(1);
    run = 1'b0; bid_valid = 1'b0; ask_valid = 1'b0;
    step(1);
    check_eq("rd_busy", m0_busy, 0);
    check_eq("rd_match", m0_match, 0);
    check_eq("rd_count", m0_count, 4);
    run = 1'b1;

    // Async reset in the middle of the MATCH cycle.
    set_book(8'd60, 8'd5, 8'd55, 8'd3);
    step(2);
    check_eq("ar_pre_match", m0_match, 1);
    check_eq("ar_pre_count", m0_count, 5);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_match", m0_match, 0);
    check_eq("ar_bfill", m0_bfill, 0);
    check_eq("ar_afill", m0_afill, 0);
    check_eq("ar_count", m0_count, 0);
    check_eq("ar_busy", m0_busy, 0);
    check_eq("ar_buy", m0_buy, 0);
    bid_valid = 1'b0; ask_valid = 1'b0;
    step(1);
    reset = 1'b1;

    // dut1: valids held crossed; strobe period is 6 edges (1 high, 5 low) with GAP_CYCLES=3.
    // An update during the first SETTLE must not shorten it. Then 16 matches wrap a 4-bit count.
    set_book(8'd60, 8'd5, 8'd55, 8'd3);
    seen = 0;
    cyc  = 0;
    last = -100;
    while (seen < 16 && cyc < 200) begin
      book_update = (seen == 1 && cyc == last + 1);
      step(1);
      cyc++;
      if (m1_match) begin
        seen++;
        if (seen == 2) check_eq("gap_period", cyc - last, 6);
        if (seen == 15) check_eq("wrap_count15", m1_count, 15);
        last = cyc;
      end
    end
    book_update = 1'b0;
    check_eq("wrap_seen", seen, 16);
    check_eq("wrap_count", m1_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
